codec_capture: RTL and testbench
================================

# codec_capture

Record-path receiver for the AC97 codec link. It takes raw ADC samples from the codec interface, frame-aligned by the raw `New_Frame` strobe. It buffers them in a small FIFO and hands them to a downstream consumer over a valid/ready handshake. It is the inbound counterpart of the playback path, which drives `sample_out` toward the codec on `New_Frame`.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, at least 2.
- `AW`, 2: log2(`DEPTH`).
- `clk`  in  1  system clock; the same clock as the codec interface.
- `reset`  in  1  asynchronous, active-low reset.
- `New_Frame`  in  1  raw frame strobe from the codec interface. It may stay high for several cycles.
- `sample_in`  in  16  signed ADC sample. Stable whenever `New_Frame` is high.
- `enable`  in  1  capture enable, level-sensitive.
- `clear`  in  1  synchronous one-cycle pulse that clears sticky status.
- `sample_out`  out  16  head of the FIFO.
- `sample_valid`  out  1  FIFO is non-empty.
- `sample_ready`  in  1  consumer accepts `sample_out` this cycle.
- `level`  out  AW+1  current FIFO fill count, from 0 to `DEPTH`.
- `overflow`  out  1  sticky flag: a sample was dropped because the FIFO was full.
- `peak`  out  15  largest captured magnitude. Present only with `CODEC_CAPTURE_PEAK_EN`.

## Operation
- **Frame edge.** `nf_q` holds `New_Frame` delayed one cycle. `frame_edge = New_Frame & ~nf_q`, one cycle per frame regardless of strobe width.
- **FSM states:** IDLE, ARM, RUN.
  - IDLE → ARM when `enable` = 1.
  - ARM → RUN on the first `frame_edge`. That frame's sample is discarded, because it may be partial.
  - RUN: every `frame_edge` is a push request.
  - ARM or RUN → IDLE whenever `enable` = 0, taking priority over everything else.
- **FIFO contents across IDLE.** Contents are retained in IDLE and stay drainable. `enable` never flushes the FIFO.
- **Push.** `sample_in` is written at the tail when a push is requested and (not full, or a pop happens in the same cycle).
- **Drop.** If a push is requested while full with no pop in that cycle, the sample is dropped and `overflow` is set.
- **Pop.** A pop occurs when `sample_valid & sample_ready`. The head advances, and the FIFO is first-word-fall-through.
- **Simultaneous push and pop.**
  - `level` is unchanged.
  - When full, the push is accepted and no overflow occurs.
  - When empty, only the push happens, since `sample_valid` was 0.
- **`level`.** Updated as +1 on push only, −1 on pop only, and 0 change on both or neither. Pointers are AW bits and wrap modulo `DEPTH`.
- **`clear`.** Clears `overflow` (and `peak` if present). If a drop happens in the same cycle, `overflow` ends up 1: the set wins.
- **`peak`.** With `CODEC_CAPTURE_PEAK_EN`, an accepted push updates `peak` to max(`peak`, |`sample_in`|), with the magnitude computed as follows:
  - Take the two's-complement magnitude.
  - Saturate −32768 to 32767.
  - The result fits 15 bits.

## Timing
- **Reset values** (`reset` = 0, asynchronous):
  - State IDLE, `nf_q` = 0, pointers 0.
  - `sample_out` = 0, `sample_valid` = 0, `level` = 0, `overflow` = 0, `peak` = 0.
- **Reset release.** Normal operation starts on the first rising clock edge after release.
- **Frame-edge latency.** `New_Frame` is first sampled high at edge N. `frame_edge` is true in the cycle before edge N, and the write happens at edge N.
- **Push-to-output latency.** If the FIFO was empty, `sample_valid` = 1 and `sample_out` = the written sample right after edge N: 1 cycle from `frame_edge`.
- **Pop.** Takes effect at the clock edge where `valid & ready`. The next entry appears after that edge.
- **Consumer rules.**
  - The consumer may hold `sample_ready` high permanently.
  - `sample_out` must not change while `sample_valid` = 1 and no pop has occurred.
- **Reset mid-operation.** Loses all FIFO contents. The FSM re-arms, so the first post-reset frame is discarded again.
- **`enable` falling in the same cycle as `frame_edge`.** No push occurs.

## Configuration
- **`CODEC_CAPTURE_PEAK_EN` defined:**
  - The `peak` port and its 15-bit register are present.
  - `peak` is cleared by `clear` and by reset.
- **`CODEC_CAPTURE_PEAK_EN` undefined:**
  - The `peak` port and its logic are absent.
  - All other behaviour is identical.

## Structure
- **Package `codec_capture_pkg`:**
  - `SAMPLE_W` = 16.
  - `PEAK_W` = 15.
  - State enum `cap_state_t` {IDLE, ARM, RUN}.
- **Sub-module `sample_fifo`** (parameters `DEPTH`, `AW`):
  - Push/pop, pointers, `level`, and a full/empty derivation.
- **Top level:** FSM, edge detect, overflow, and peak.

## Test plan
- **Arm discard.** Reset, `enable` = 1, frames with samples 0x0101, 0x0202, 0x0303, `sample_ready` = 1 → 0x0202 then 0x0303 appear, each valid exactly one cycle after its frame edge.
- **Long strobe.** `New_Frame` held high 5 cycles per frame, in RUN → exactly one push per frame; `level` increments by 1.
- **Overflow.** `DEPTH` = 4, `sample_ready` = 0, 5 frames in RUN → `level` = 4 and `overflow` = 1. After draining, exactly the first 4 samples come out in order.
- **Full with pop.** FIFO full, `frame_edge` coincident with a pop → `level` stays 4 and `overflow` stays 0. The new sample appears last.
- **Clear and disable.**
  - `clear` coincident with a drop → `overflow` = 1.
  - `clear` alone → `overflow` = 0.
  - `enable` = 0 with 2 entries queued → both still drain, and no new pushes occur.
- **Peak** (macro on). Accepted samples 0x1000, 0x8000, 0xF000 → `peak` = 0x7FFF. After `clear` then sample 0xFFFE → `peak` = 0x0002. Reset mid-RUN → all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/codec_capture_pkg.sv
// codec_capture_pkg: shared widths, capture FSM states and sample magnitude helper.
package codec_capture_pkg;
  localparam int SAMPLE_W = 16;
  localparam int PEAK_W = 15;
  typedef enum logic [1:0] {IDLE, ARM, RUN} cap_state_t;
  // -32768 has no positive counterpart, so it saturates to the largest magnitude
  function automatic logic [PEAK_W-1:0] magnitude(input logic [SAMPLE_W-1:0] s);
    logic [SAMPLE_W-1:0] a;
    a = s[SAMPLE_W-1] ? -s : s;
    return a[SAMPLE_W-1] ? {PEAK_W{1'b1}} : a[PEAK_W-1:0];
  endfunction
endpackage

// File: rtl/sample_fifo.sv
// sample_fifo: first-word-fall-through sample FIFO; a push is accepted when full if a pop frees a slot.
module sample_fifo import codec_capture_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int AW = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                push,
  input  logic                ready,
  input  logic [SAMPLE_W-1:0] din,
  output logic [SAMPLE_W-1:0] dout,
  output logic                valid,
  output logic                accept,
  output logic [AW:0]         level
);
  logic [SAMPLE_W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic full, pop;
  assign full = level == (AW+1)'(DEPTH);
  assign valid = level != '0;
  assign pop = valid & ready;
  assign accept = push & (~full | pop);
  assign dout = valid ? mem[rd_ptr] : '0;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      level <= level + (AW+1)'(accept) - (AW+1)'(pop);
    end
  always_ff @(posedge clk)
    if (accept) mem[wr_ptr] <= din;
endmodule

// File: rtl/codec_capture.sv
// codec_capture: AC97 record-path receiver, frame-edge capture into a FIFO with valid/ready output.
// Optional peak-magnitude tracking is built when CODEC_CAPTURE_PEAK_EN is defined.
module codec_capture import codec_capture_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int AW = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                New_Frame,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                enable,
  input  logic                clear,
  output logic [SAMPLE_W-1:0] sample_out,
  output logic                sample_valid,
  input  logic                sample_ready,
  output logic [AW:0]         level,
  output logic                overflow
`ifdef CODEC_CAPTURE_PEAK_EN
  , output logic [PEAK_W-1:0] peak
`endif
);
  cap_state_t state, next;
  logic nf_q, frame_edge, push, accept;
  assign frame_edge = New_Frame & ~nf_q;
  assign push = enable & frame_edge & (state == RUN);
  // the frame seen while arming may be partial, so it only moves the FSM to RUN
  always_comb begin
    next = !enable ? IDLE :
           state == IDLE ? ARM :
           (state == ARM && frame_edge) ? RUN : state;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      nf_q <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= next;
      nf_q <= New_Frame;
      overflow <= (push & ~accept) | (overflow & ~clear);
    end
  sample_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
    .clk(clk), .reset(reset), .push(push), .ready(sample_ready), .din(sample_in),
    .dout(sample_out), .valid(sample_valid), .accept(accept), .level(level)
  );
`ifdef CODEC_CAPTURE_PEAK_EN
  logic [PEAK_W-1:0] mag, base;
  assign mag = magnitude(sample_in);
  assign base = clear ? '0 : peak;
  always_ff @(posedge clk or negedge reset)
    if (!reset) peak <= '0;
    else peak <= (accept && mag > base) ? mag : base;
`endif
endmodule

// File: tb/tb_codec_capture.sv
// tb_codec_capture: randomized and directed checks of codec_capture against a queue-based reference model.
module tb_codec_capture;
  localparam int DEPTH = 4;
  localparam int AW = 2;
  logic clk = 0, reset = 0, New_Frame = 0, enable = 0, clear = 0, sample_ready = 0;
  logic [15:0] sample_in = '0;
  logic [15:0] sample_out;
  logic sample_valid, overflow;
  logic [AW:0] level;
`ifdef CODEC_CAPTURE_PEAK_EN
  logic [14:0] peak;
`endif
  int checks = 0, failures = 0;
  logic [15:0] q[$];
  bit m_ovf, m_prev_nf, m_active, m_first;
  logic [14:0] m_peak;

  always #5 clk = ~clk;

  codec_capture #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset), .New_Frame(New_Frame), .sample_in(sample_in),
    .enable(enable), .clear(clear), .sample_out(sample_out), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .level(level), .overflow(overflow)
`ifdef CODEC_CAPTURE_PEAK_EN
    , .peak(peak)
`endif
  );

  function automatic logic [14:0] ref_mag(input logic [15:0] s);
    int v;
    v = $signed(s);
    if (v < 0) v = -v;
    if (v > 32767) v = 32767;
    return 15'(v);
  endfunction

  function automatic logic [4:0] exp_status();
    return {q.size() != 0, 3'(q.size()), m_ovf};
  endfunction

  task automatic model_reset();
    q.delete();
    m_ovf = 0; m_prev_nf = 0; m_active = 0; m_first = 0; m_peak = '0;
  endtask

  // drive one cycle of inputs, advance the reference model, return #1 after the edge
  task automatic cycle(input bit nf, input logic [15:0] s, input bit en, input bit rdy, input bit clr);
    bit fe, req, acc;
    New_Frame = nf; sample_in = s; enable = en; sample_ready = rdy; clear = clr;
    fe = nf && !m_prev_nf;
    req = 0;
    if (en && m_active && fe) begin
      if (m_first) req = 1;
      else m_first = 1;
    end
    if (!en) m_first = 0;
    m_active = en;
    m_prev_nf = nf;
    if (q.size() != 0 && rdy) void'(q.pop_front());
    acc = req && q.size() < DEPTH;
    if (acc) q.push_back(s);
    if (req && !acc) m_ovf = 1;
    else if (clr) m_ovf = 0;
    if (clr) m_peak = '0;
    if (acc && ref_mag(s) > m_peak) m_peak = ref_mag(s);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({sample_valid, level, overflow, sample_out} !== 21'd0) begin
      failures++; $display("FAIL reset_values got=%h exp=0", {sample_valid, level, overflow, sample_out});
    end
`ifdef CODEC_CAPTURE_PEAK_EN
    checks++;
    if (peak !== 15'd0) begin failures++; $display("FAIL reset_peak got=%h exp=0", peak); end
`endif
    model_reset();
    @(negedge clk) reset = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_arm_discard();
    logic [15:0] smp[3] = '{16'h0101, 16'h0202, 16'h0303};
    logic [15:0] got[$];
    cycle(0, 16'h0, 1, 1, 0);
    for (int f = 0; f < 3; f++)
      for (int c = 0; c < 5; c++) begin
        cycle(c < 2, smp[f], 1, 1, 0);
        checks++;
        if ({sample_valid, level, overflow} !== exp_status()) begin
          failures++; $display("FAIL arm_status got=%b exp=%b", {sample_valid, level, overflow}, exp_status());
        end
        if (q.size() != 0) begin
          checks++;
          if (sample_out !== q[0]) begin failures++; $display("FAIL arm_out got=%h exp=%h", sample_out, q[0]); end
        end
        if (sample_valid) got.push_back(sample_out);
      end
    checks++;
    if (got.size() != 2 || got[0] !== 16'h0202 || got[1] !== 16'h0303) begin
      failures++; $display("FAIL arm_sequence got=%p exp=0202,0303", got);
    end
  endtask

  task automatic test_long_strobe();
    logic [15:0] s;
    for (int f = 0; f < 2; f++) begin
      s = 16'($urandom);
      for (int c = 0; c < 7; c++) begin
        cycle(c < 5, s, 1, 0, 0);
        checks++;
        if ({sample_valid, level, overflow} !== exp_status()) begin
          failures++; $display("FAIL long_status got=%b exp=%b", {sample_valid, level, overflow}, exp_status());
        end
      end
    end
    checks++;
    if (level !== 3'd2) begin failures++; $display("FAIL long_level got=%0d exp=2", level); end
  endtask

  task automatic test_overflow();
    logic [15:0] smp[5];
    logic [15:0] got[$];
    repeat (3) cycle(0, 16'h0, 1, 1, 0);
    for (int f = 0; f < 5; f++) begin
      smp[f] = 16'($urandom);
      cycle(1, smp[f], 1, 0, 0);
      cycle(0, smp[f], 1, 0, 0);
      checks++;
      if ({sample_valid, level, overflow} !== exp_status()) begin
        failures++; $display("FAIL ovf_status got=%b exp=%b", {sample_valid, level, overflow}, exp_status());
      end
    end
    checks++;
    if (level !== 3'd4 || overflow !== 1'b1) begin
      failures++; $display("FAIL ovf_full got=%0d/%b exp=4/1", level, overflow);
    end
    repeat (6) begin
      if (sample_valid) got.push_back(sample_out);
      cycle(0, 16'h0, 1, 1, 0);
    end
    checks++;
    if (got.size() != 4 || got[0] !== smp[0] || got[1] !== smp[1] || got[2] !== smp[2] || got[3] !== smp[3]) begin
      failures++; $display("FAIL ovf_drain got=%p exp=%h,%h,%h,%h", got, smp[0], smp[1], smp[2], smp[3]);
    end
  endtask

  task automatic test_full_pop();
    logic [15:0] s;
    cycle(0, 16'h0, 1, 0, 1);
    repeat (4) begin
      s = 16'($urandom);
      cycle(1, s, 1, 0, 0);
      cycle(0, s, 1, 0, 0);
    end
    s = 16'($urandom);
    cycle(1, s, 1, 1, 0);
    checks++;
    if (level !== 3'd4 || overflow !== 1'b0) begin
      failures++; $display("FAIL fullpop_status got=%0d/%b exp=4/0", level, overflow);
    end
    checks++;
    if ({sample_valid, level, overflow} !== exp_status() || sample_out !== q[0]) begin
      failures++; $display("FAIL fullpop_model got=%b/%h exp=%b/%h", {sample_valid, level, overflow}, sample_out, exp_status(), q[0]);
    end
    cycle(0, s, 1, 0, 0);
  endtask

  task automatic test_clear_disable();
    logic [15:0] s;
    s = 16'($urandom);
    cycle(1, s, 1, 0, 1);
    checks++;
    if (overflow !== 1'b1) begin failures++; $display("FAIL clear_with_drop got=%b exp=1", overflow); end
    cycle(0, s, 1, 0, 1);
    checks++;
    if (overflow !== 1'b0) begin failures++; $display("FAIL clear_alone got=%b exp=0", overflow); end
    for (int c = 0; c < 12; c++) begin
      cycle(c >= 2 && c[0], 16'($urandom), c < 2, c < 2 || c >= 8, 0);
      checks++;
      if ({sample_valid, level, overflow} !== exp_status()) begin
        failures++; $display("FAIL disable_status got=%b exp=%b", {sample_valid, level, overflow}, exp_status());
      end
      if (q.size() != 0) begin
        checks++;
        if (sample_out !== q[0]) begin failures++; $display("FAIL disable_out got=%h exp=%h", sample_out, q[0]); end
      end
      if (c == 7) begin
        checks++;
        if (level !== 3'd2) begin failures++; $display("FAIL disable_hold got=%0d exp=2", level); end
      end
    end
    checks++;
    if (level !== 3'd0) begin failures++; $display("FAIL disable_drain got=%0d exp=0", level); end
  endtask

  task automatic test_random();
    bit nf = 0;
    logic [15:0] s = '0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 2) == 0) nf = ~nf;
      if (!nf && $urandom_range(0, 1) == 1) s = 16'($urandom);
      cycle(nf, s, $urandom_range(0, 39) != 0, $urandom_range(0, 3) < (i < 300 ? 1 : 3), $urandom_range(0, 29) == 0);
      checks++;
      if ({sample_valid, level, overflow} !== exp_status()) begin
        failures++; $display("FAIL random_status i=%0d got=%b exp=%b", i, {sample_valid, level, overflow}, exp_status());
      end
      if (q.size() != 0) begin
        checks++;
        if (sample_out !== q[0]) begin failures++; $display("FAIL random_out i=%0d got=%h exp=%h", i, sample_out, q[0]); end
      end
    end
  endtask

  task automatic test_reset_mid();
    cycle(0, 16'h0, 1, 0, 0);
    for (int f = 0; f < 3; f++) begin
      cycle(1, 16'($urandom), 1, 0, 0);
      cycle(0, 16'h0, 1, 0, 0);
    end
    New_Frame = 0; enable = 0; sample_ready = 0; clear = 0;
    #2 reset = 0;
    #1;
    checks++;
    if ({sample_valid, level, overflow, sample_out} !== 21'd0) begin
      failures++; $display("FAIL reset_mid got=%h exp=0", {sample_valid, level, overflow, sample_out});
    end
`ifdef CODEC_CAPTURE_PEAK_EN
    checks++;
    if (peak !== 15'd0) begin failures++; $display("FAIL reset_mid_peak got=%h exp=0", peak); end
`endif
    model_reset();
    @(negedge clk) reset = 1;
    @(posedge clk); #1;
    cycle(0, 16'h0, 1, 1, 0);
    cycle(1, 16'h1234, 1, 1, 0);
    checks++;
    if (sample_valid !== 1'b0) begin failures++; $display("FAIL rearm_discard got=%b exp=0", sample_valid); end
    cycle(0, 16'h1234, 1, 1, 0);
    cycle(1, 16'h5678, 1, 1, 0);
    checks++;
    if (sample_valid !== 1'b1 || sample_out !== 16'h5678) begin
      failures++; $display("FAIL rearm_push got=%b/%h exp=1/5678", sample_valid, sample_out);
    end
    cycle(0, 16'h0, 1, 1, 0);
  endtask

`ifdef CODEC_CAPTURE_PEAK_EN
  task automatic test_peak();
    logic [15:0] smp[4] = '{16'h1000, 16'h8000, 16'hF000, 16'hFFFE};
    cycle(0, 16'h0, 1, 1, 1);
    for (int f = 0; f < 4; f++) begin
      if (f == 3) cycle(0, 16'h0, 1, 1, 1);
      cycle(1, smp[f], 1, 1, 0);
      cycle(0, smp[f], 1, 1, 0);
      checks++;
      if (peak !== m_peak) begin failures++; $display("FAIL peak_model got=%h exp=%h", peak, m_peak); end
      if (f == 2) begin
        checks++;
        if (peak !== 15'h7FFF) begin failures++; $display("FAIL peak_sat got=%h exp=7fff", peak); end
      end
    end
    checks++;
    if (peak !== 15'h0002) begin failures++; $display("FAIL peak_after_clear got=%h exp=0002", peak); end
  endtask
`endif

  initial begin
    test_reset();
    test_arm_discard();
    test_long_strobe();
    test_overflow();
    test_full_pop();
    test_clear_disable();
    test_random();
    test_reset_mid();
`ifdef CODEC_CAPTURE_PEAK_EN
    test_peak();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
